// File: rtl/id_scoreboard_pkg.sv
// Shared scoreboard definitions: default result latencies and the per-entry counter action encoding.
package id_scoreboard_pkg;

    localparam int unsigned LAT_ALU = 0;
    localparam int unsigned LAT_LDW = 1;

    typedef enum logic [1:0] {
        CNT_HOLD  = 2'd0,
        CNT_CLEAR = 2'd1,
        CNT_LOAD  = 2'd2,
        CNT_DEC   = 2'd3
    } cnt_op_e;

endpackage

// File: rtl/id_scoreboard_sb_entry.sv
// One scoreboard entry: a saturating down-counter of bubbles remaining before the register is forwardable.
module sb_entry
    import id_scoreboard_pkg::*;
#(
    parameter int unsigned LAT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [LAT_W-1:0] cnt_o,
    output logic             busy_o
);

    cnt_op_e          op;
    logic [LAT_W-1:0] cnt_q, cnt_d;

    // Clear beats load, load beats decrement.
    always_comb begin
        op = CNT_HOLD;
        if (clear_i) begin
            op = CNT_CLEAR;
        end else if (load_i) begin
            op = CNT_LOAD;
        end else if (dec_i && (cnt_q != '0)) begin
            op = CNT_DEC;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case (op)
            CNT_CLEAR: cnt_d = '0;
            CNT_LOAD:  cnt_d = load_val_i;
            CNT_DEC:   cnt_d = cnt_q - LAT_W'(1);
            default:   cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage GPR scoreboard: per-register latency counters with source (RAW) and WAW hazard detection.
module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned LAT_W     = 3,
    parameter int unsigned HARD_ZERO = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 dec_valid,
    input  logic [REG_AW-1:0]    dec_ra_addr,
    input  logic [REG_AW-1:0]    dec_rb_addr,
    input  logic                 dec_use_ra,
    input  logic                 dec_use_rb,
    input  logic [REG_AW-1:0]    dec_dst_addr,
    input  logic                 dec_we,
    input  logic [LAT_W-1:0]     dec_lat,
    output logic                 hazard,
    output logic                 issue,
    output logic [2**REG_AW-1:0] busy_vec,
    output logic                 sb_idle
);

    localparam int unsigned NREG = 2**REG_AW;

    logic [LAT_W-1:0] cnt [NREG];
    logic             ra_live, rb_live, dst_live;
    logic             src_hz, waw_hz;

    // With a hardwired zero register, r0 is masked out of every hazard term.
    assign ra_live  = dec_use_ra && !((HARD_ZERO != 0) && (dec_ra_addr == '0));
    assign rb_live  = dec_use_rb && !((HARD_ZERO != 0) && (dec_rb_addr == '0));
    assign dst_live = dec_we && !((HARD_ZERO != 0) && (dec_dst_addr == '0));

    assign src_hz = (ra_live && (cnt[dec_ra_addr] != '0)) ||
                    (rb_live && (cnt[dec_rb_addr] != '0));
    assign waw_hz = dst_live && (cnt[dec_dst_addr] > dec_lat);

    assign hazard  = dec_valid && (src_hz || waw_hz);
    assign issue   = dec_valid && !hazard && !stall && !flush;
    assign sb_idle = ~|busy_vec;

    for (genvar i = 0; i < NREG; i++) begin : g_entry
        logic load;

        if ((HARD_ZERO != 0) && (i == 0)) begin : g_zero
            assign load = 1'b0;
        end else begin : g_live
            assign load = issue && dec_we && (dec_dst_addr == REG_AW'(i));
        end

        sb_entry #(
            .LAT_W (LAT_W)
        ) u_entry (
            .clk_i      (clk),
            .rst_ni     (reset),
            .clear_i    (flush),
            .load_i     (load),
            .load_val_i (dec_lat),
            .dec_i      (!stall),
            .cnt_o      (cnt[i]),
            .busy_o     (busy_vec[i])
        );
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed self-checking bench for id_scoreboard, with a second HARD_ZERO=1 instance sharing the stimulus.
module tb_id_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, dec_valid, dec_use_ra, dec_use_rb, dec_we;
    logic [4:0]  dec_ra_addr, dec_rb_addr, dec_dst_addr;
    logic [2:0]  dec_lat;
    logic        hazard, issue, sb_idle;
    logic [31:0] busy_vec;
    logic        hz_hazard, hz_issue, hz_sb_idle;
    logic [31:0] hz_busy_vec;

    int errors = 0;
    int checks = 0;
    int nhz;
    int nhz_cyc;

    always #5 clk = ~clk;

    id_scoreboard #(.REG_AW(5), .LAT_W(3), .HARD_ZERO(0)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .dec_valid(dec_valid),
        .dec_ra_addr(dec_ra_addr), .dec_rb_addr(dec_rb_addr), .dec_use_ra(dec_use_ra),
        .dec_use_rb(dec_use_rb), .dec_dst_addr(dec_dst_addr), .dec_we(dec_we), .dec_lat(dec_lat),
        .hazard(hazard), .issue(issue), .busy_vec(busy_vec), .sb_idle(sb_idle)
    );

    id_scoreboard #(.REG_AW(5), .LAT_W(3), .HARD_ZERO(1)) u_hz (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .dec_valid(dec_valid),
        .dec_ra_addr(dec_ra_addr), .dec_rb_addr(dec_rb_addr), .dec_use_ra(dec_use_ra),
        .dec_use_rb(dec_use_rb), .dec_dst_addr(dec_dst_addr), .dec_we(dec_we), .dec_lat(dec_lat),
        .hazard(hz_hazard), .issue(hz_issue), .busy_vec(hz_busy_vec), .sb_idle(hz_sb_idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setdec(input logic v, input logic [4:0] ra, input logic ua,
                          input logic [4:0] rb, input logic ub,
                          input logic [4:0] dst, input logic we, input logic [2:0] lat);
        dec_valid = v;  dec_ra_addr = ra; dec_use_ra = ua;
        dec_rb_addr = rb; dec_use_rb = ub;
        dec_dst_addr = dst; dec_we = we; dec_lat = lat;
    endtask

    task automatic idle();
        setdec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    endtask

    // Holds the current instruction until the plain instance issues it; counts its hazard cycles.
    task automatic count_hazards(input int stall_cycles, output int n);
        n = 0;
        nhz_cyc = 0;
        for (int c = 0; c < 20; c++) begin
            stall = (c < stall_cycles);
            #1;
            if (hazard) n++;
            if (issue) break;
            nhz_cyc++;
            tick();
        end
        stall = 1'b0;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        idle();
        #12;
        chk("rst_busy_vec", busy_vec, 32'h0);
        chk("rst_sb_idle", {31'd0, sb_idle}, 32'd1);
        chk("rst_hazard", {31'd0, hazard}, 32'd0);
        chk("rst_issue", {31'd0, issue}, 32'd0);
        #2 reset = 1'b1;
        tick();

        // LDW r3 (lat 1) then a reader of r3
        setdec(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b1, 3'd1);
        #1 chk("ldw_issue", {31'd0, issue}, 32'd1);
        tick();
        setdec(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd8, 1'b1, 3'd0);
        #1 chk("raw_hazard", {31'd0, hazard}, 32'd1);
        chk("raw_no_issue", {31'd0, issue}, 32'd0);
        chk("raw_busy3", busy_vec, 32'h0000_0008);
        tick();
        #1 chk("raw_clear_hazard", {31'd0, hazard}, 32'd0);
        chk("raw_issue", {31'd0, issue}, 32'd1);
        chk("raw_busy_zero", busy_vec, 32'h0);
        tick();
        idle();

        // MUL r5 lat 4, two stalled cycles, then a dependent read
        setdec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd4);
        #1 chk("mul_issue", {31'd0, issue}, 32'd1);
        tick();
        setdec(1'b1, 5'd9, 1'b0, 5'd5, 1'b1, 5'd10, 1'b1, 3'd0);
        stall = 1'b1;
        #1 chk("stall_blocks_issue", {31'd0, issue}, 32'd0);
        chk("stall_hazard_kept", {31'd0, hazard}, 32'd1);
        count_hazards(2, nhz);
        chk("mul_hazard_cycles", nhz, 32'd6);
        chk("mul_issue_cycle", nhz_cyc, 32'd6);
        tick();
        idle();

        // WAW on r7: lat 4 then lat 1 then lat 0
        setdec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd4);
        #1 chk("waw_first_issue", {31'd0, issue}, 32'd1);
        tick();
        setdec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd1);
        count_hazards(0, nhz);
        chk("waw_lat1_hazards", nhz, 32'd3);
        tick();
        setdec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd0);
        count_hazards(0, nhz);
        chk("waw_lat0_hazards", nhz, 32'd1);
        tick();
        idle();
        #1 chk("waw_end_idle", {31'd0, sb_idle}, 32'd1);

        // Lat-5 to r2, flush one cycle later
        setdec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 3'd5);
        tick();
        idle();
        flush = 1'b1;
        #1 chk("pre_flush_busy2", busy_vec, 32'h0000_0004);
        tick();
        flush = 1'b0;
        #1 chk("flush_busy_zero", busy_vec, 32'h0);
        chk("flush_idle", {31'd0, sb_idle}, 32'd1);
        setdec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 3'd0);
        #1 chk("flush_reader_hazard", {31'd0, hazard}, 32'd0);
        chk("flush_reader_issue", {31'd0, issue}, 32'd1);
        tick();

        // Flush wins over stall and over a would-be load
        setdec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 3'd3);
        tick();
        setdec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd2);
        flush = 1'b1; stall = 1'b1;
        #1 chk("flush_stall_hazard", {31'd0, hazard}, 32'd0);
        chk("flush_stall_issue", {31'd0, issue}, 32'd0);
        chk("flush_stall_busy6", busy_vec, 32'h0000_0040);
        tick();
        flush = 1'b0; stall = 1'b0;
        idle();
        #1 chk("flush_over_stall", busy_vec, 32'h0);

        // Lat-3 write to r0, then an r0 reader on both instances
        setdec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd3);
        #1 chk("r0_write_issue", {31'd0, issue}, 32'd1);
        tick();
        setdec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 3'd0);
        #1 chk("hz_r0_hazard", {31'd0, hz_hazard}, 32'd0);
        chk("hz_r0_issue", {31'd0, hz_issue}, 32'd1);
        chk("hz_r0_busy", hz_busy_vec, 32'h0);
        chk("hz_idle", {31'd0, hz_sb_idle}, 32'd1);
        chk("nz_r0_busy", busy_vec, 32'h0000_0001);
        count_hazards(0, nhz);
        chk("nz_r0_hazards", nhz, 32'd3);
        tick();
        idle();

        // Reset mid-operation while cnt[4]=3
        setdec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd5);
        tick();
        idle();
        tick();
        tick();
        chk("pre_reset_busy4", busy_vec, 32'h0000_0010);
        #2 reset = 1'b0;
        #1 chk("async_reset_busy", busy_vec, 32'h0);
        chk("async_reset_idle", {31'd0, sb_idle}, 32'd1);
        tick();
        #2 reset = 1'b1;
        tick();
        setdec(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 3'd0);
        #1 chk("post_reset_hazard", {31'd0, hazard}, 32'd0);
        chk("post_reset_issue", {31'd0, issue}, 32'd1);
        chk("post_reset_busy", busy_vec, 32'h0);
        tick();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
